// File: rtl/square_wave_gen.sv
// square_wave_gen: programmable square-wave source with period/high time in clk cycles.
// Ports: clk, rst_n, period_in/high_in/cfg_valid/cfg_ready/cfg_err (config), enable,
//        signal_out, cycle_start, running, active_period.
module square_wave_gen #(
  parameter int COUNTER_WIDTH = 18,
  parameter int MIN_PERIOD    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [COUNTER_WIDTH-1:0] period_in,
  input  logic [COUNTER_WIDTH-1:0] high_in,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  output logic                     cfg_err,
  input  logic                     enable,
  output logic                     signal_out,
  output logic                     cycle_start,
  output logic                     running,
  output logic [COUNTER_WIDTH-1:0] active_period
);

  localparam int W = COUNTER_WIDTH;
  localparam logic [W-1:0] MINP = W'(MIN_PERIOD);
  localparam logic [W-1:0] ONE  = W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0] r_act_period;
  logic [W-1:0] r_act_high;
  logic         r_act_ok;
  logic [W-1:0] r_pend_period;
  logic [W-1:0] r_pend_high;
  logic         r_pend_valid;
  logic [W-1:0] r_cnt;
  logic         r_signal;
  logic         r_cycle_start;
  logic         r_cfg_err;

  logic         w_accept;
  logic         w_legal;
  logic         w_cfg_ok;
  logic         w_wrap;
  logic [W-1:0] w_cnt_nxt;
  logic         w_start;
  logic         w_stop;

  assign w_accept  = cfg_valid & ~r_pend_valid;
  assign w_legal   = (period_in >= MINP) &&
                     (high_in >= ONE) &&
                     (high_in < period_in);
  assign w_cfg_ok  = w_accept & w_legal;
  assign w_wrap    = (r_cnt == r_act_period - ONE);
  assign w_cnt_nxt = w_wrap ? '0 : r_cnt + ONE;

  // Start sees the active values as they will be after this edge:
  // a leftover pending entry or a request accepted right now.
  assign w_start = (r_state == S_IDLE) & enable &
                   (r_act_ok | r_pend_valid | w_cfg_ok);
  assign w_stop  = (r_state == S_RUN) & w_wrap & ~enable;

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      w_start: w_state_nxt = S_RUN;
      w_stop:  w_state_nxt = S_IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_period  <= '0;
      r_act_high    <= '0;
      r_act_ok      <= 1'b0;
      r_pend_period <= '0;
      r_pend_high   <= '0;
      r_pend_valid  <= 1'b0;
      r_cnt         <= '0;
      r_signal      <= 1'b0;
      r_cycle_start <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_cfg_err     <= w_accept & ~w_legal;
      r_cycle_start <= 1'b0;
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
        if (r_pend_valid) begin
          r_act_period <= r_pend_period;
          r_act_high   <= r_pend_high;
          r_act_ok     <= 1'b1;
          r_pend_valid <= 1'b0;
        end else if (w_cfg_ok) begin
          r_act_period <= period_in;
          r_act_high   <= high_in;
          r_act_ok     <= 1'b1;
        end
        r_signal      <= w_start;
        r_cycle_start <= w_start;
      end else begin
        // Accept needs an empty buffer, so it never races the transfer.
        if (w_cfg_ok) begin
          r_pend_period <= period_in;
          r_pend_high   <= high_in;
          r_pend_valid  <= 1'b1;
        end
        if (w_stop) begin
          r_cnt    <= '0;
          r_signal <= 1'b0;
        end else begin
          r_cnt         <= w_cnt_nxt;
          r_signal      <= (w_cnt_nxt < r_act_high);
          r_cycle_start <= w_wrap;
          if (w_wrap && r_pend_valid) begin
            r_act_period <= r_pend_period;
            r_act_high   <= r_pend_high;
            r_pend_valid <= 1'b0;
          end
        end
      end
    end
  end

  assign cfg_ready     = ~r_pend_valid;
  assign cfg_err       = r_cfg_err;
  assign signal_out    = r_signal;
  assign cycle_start   = r_cycle_start;
  assign running       = (r_state == S_RUN);
  assign active_period = r_act_period;

endmodule

// File: tb/tb_square_wave_gen.sv
// tb_square_wave_gen: self-checking bench for square_wave_gen.
// Period-position reference model plus directed scenarios and random traffic.
module tb_square_wave_gen;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] period_in = '0;
  logic [W-1:0] high_in = '0;
  logic         cfg_valid = 1'b0;
  logic         enable = 1'b0;
  logic         cfg_ready;
  logic         cfg_err;
  logic         signal_out;
  logic         cycle_start;
  logic         running;
  logic [W-1:0] active_period;

  int checks = 0;
  int failures = 0;

  bit m_run;
  int m_pos;
  int m_ap;
  int m_ah;
  bit m_ok;
  bit m_pv;
  int m_pp;
  int m_ph;
  bit m_err;

  square_wave_gen #(
    .COUNTER_WIDTH(W),
    .MIN_PERIOD(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .period_in(period_in),
    .high_in(high_in),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_err(cfg_err),
    .enable(enable),
    .signal_out(signal_out),
    .cycle_start(cycle_start),
    .running(running),
    .active_period(active_period)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] dut_vec();
    return {signal_out, cycle_start, running,
            cfg_ready, cfg_err, active_period};
  endfunction

  // Output is high for the first act_high positions of each period.
  function automatic logic [22:0] mdl_vec();
    logic s, c;
    logic [W-1:0] ap;
    s  = m_run && (m_pos < m_ah);
    c  = m_run && (m_pos == 0);
    ap = W'(m_ap);
    return {s, c, logic'(m_run), logic'(!m_pv), logic'(m_err), ap};
  endfunction

  function automatic void model_reset();
    m_run = 0; m_pos = 0; m_ap = 0; m_ah = 0; m_ok = 0;
    m_pv = 0; m_pp = 0; m_ph = 0; m_err = 0;
  endfunction

  function automatic void model_step();
    bit acc, legal;
    int p, h;
    p = int'(period_in);
    h = int'(high_in);
    acc = cfg_valid && !m_pv;
    legal = (p >= 2) && (h >= 1) && (h < p);
    m_err = acc && !legal;
    if (!m_run) begin
      if (m_pv) begin
        m_ap = m_pp; m_ah = m_ph; m_ok = 1; m_pv = 0;
      end else if (acc && legal) begin
        m_ap = p; m_ah = h; m_ok = 1;
      end
      if (enable && m_ok) begin
        m_run = 1; m_pos = 0;
      end
    end else begin
      if (m_pos == m_ap - 1) begin
        m_pos = 0;
        if (!enable) m_run = 0;
        else if (m_pv) begin
          m_ap = m_pp; m_ah = m_ph; m_pv = 0;
        end
      end else begin
        m_pos++;
      end
      if (acc && legal) begin
        m_pp = p; m_ph = h; m_pv = 1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    enable = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (dut_vec() !== {5'b00010, 18'd0}) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", dut_vec(), {5'b00010, 18'd0});
    end
    enable = 1'b1;
    tick();
    tick();
    checks++;
    if (dut_vec() !== {5'b00010, 18'd0}) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", dut_vec(), {5'b00010, 18'd0});
    end
    enable = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int highs, starts;
    do_reset();
    period_in = W'(10); high_in = W'(3);
    cfg_valid = 1'b1; enable = 1'b1;
    highs = 0; starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cfg_valid = 1'b0;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL basic c=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
      highs += int'(signal_out);
      starts += int'(cycle_start);
    end
    checks++;
    if (highs != 6 || starts != 2 || active_period !== W'(10)) begin
      failures++;
      $display("FAIL basic_shape highs=%0d starts=%0d ap=%0d exp 6 2 10",
               highs, starts, active_period);
    end
  endtask

  task automatic test_illegal();
    int pr[3] = '{1, 5, 5};
    int hr[3] = '{0, 5, 0};
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      period_in = W'(pr[i]); high_in = W'(hr[i]);
      cfg_valid = 1'b1;
      tick();
      checks++;
      if (dut_vec() !== mdl_vec() || cfg_err !== 1'b1) begin
        failures++;
        $display("FAIL illegal_%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
    cfg_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec() || cfg_err !== 1'b0 ||
          running !== 1'b0 || signal_out !== 1'b0) begin
        failures++;
        $display("FAIL illegal_idle got=%h exp=%h", dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_midrun_change();
    int budget;
    logic [3:0] pat;
    do_reset();
    period_in = W'(10); high_in = W'(3);
    cfg_valid = 1'b1; enable = 1'b1;
    tick();
    cfg_valid = 1'b0;
    budget = 20;
    while (m_pos != 5 && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (budget == 0) begin
      failures++;
      $display("FAIL midrun_wait got=%0d required=5", m_pos);
    end
    period_in = W'(4); high_in = W'(2); cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (dut_vec() !== mdl_vec() || cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrun_accept got=%h exp=%h", dut_vec(), mdl_vec());
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec() || cfg_ready !== 1'b0 ||
          active_period !== W'(10)) begin
        failures++;
        $display("FAIL midrun_hold got=%h exp=%h", dut_vec(), mdl_vec());
      end
    end
    tick();
    pat = {3'b000, signal_out};
    checks++;
    if (cfg_ready !== 1'b1 || active_period !== W'(4)) begin
      failures++;
      $display("FAIL midrun_switch rdy=%b ap=%0d exp 1 4", cfg_ready, active_period);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      pat = {pat[2:0], signal_out};
    end
    checks++;
    if (pat !== 4'b1100) begin
      failures++;
      $display("FAIL midrun_pattern got=%b exp=1100", pat);
    end
  endtask

  task automatic test_accept_on_wrap();
    int budget;
    logic [5:0] pat;
    do_reset();
    period_in = W'(8); high_in = W'(4);
    cfg_valid = 1'b1; enable = 1'b1;
    tick();
    cfg_valid = 1'b0;
    budget = 20;
    while (m_pos != 7 && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (budget == 0) begin
      failures++;
      $display("FAIL wrapacc_wait got=%0d required=7", m_pos);
    end
    period_in = W'(6); high_in = W'(1); cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (dut_vec() !== mdl_vec() || active_period !== W'(8) ||
        cfg_ready !== 1'b0 || cycle_start !== 1'b1) begin
      failures++;
      $display("FAIL wrapacc_edge got=%h exp=%h", dut_vec(), mdl_vec());
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec() || active_period !== W'(8)) begin
        failures++;
        $display("FAIL wrapacc_old got=%h exp=%h", dut_vec(), mdl_vec());
      end
    end
    tick();
    pat = {5'b00000, signal_out};
    checks++;
    if (active_period !== W'(6) || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL wrapacc_new ap=%0d rdy=%b exp 6 1", active_period, cfg_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      pat = {pat[4:0], signal_out};
    end
    checks++;
    if (pat !== 6'b100000) begin
      failures++;
      $display("FAIL wrapacc_pattern got=%b exp=100000", pat);
    end
  endtask

  task automatic test_stop_resume();
    int budget, starts;
    bit gap;
    do_reset();
    period_in = W'(10); high_in = W'(3);
    cfg_valid = 1'b1; enable = 1'b1;
    tick();
    cfg_valid = 1'b0;
    budget = 20;
    while (m_pos != 2 && budget > 0) begin
      tick();
      budget--;
    end
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL stop_tail got=%h exp=%h", dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL stop_early running=%b exp=1", running);
    end
    tick();
    checks++;
    if (running !== 1'b0 || signal_out !== 1'b0 || cycle_start !== 1'b0) begin
      failures++;
      $display("FAIL stop_edge run=%b sig=%b cs=%b exp 0 0 0",
               running, signal_out, cycle_start);
    end
    repeat (3) tick();
    enable = 1'b1;
    tick();
    checks++;
    if (dut_vec() !== mdl_vec() || running !== 1'b1 || cycle_start !== 1'b1) begin
      failures++;
      $display("FAIL resume got=%h exp=%h", dut_vec(), mdl_vec());
    end
    budget = 20;
    while (m_pos != 4 && budget > 0) begin
      tick();
      budget--;
    end
    enable = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    gap = 0; starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL blip c=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
      if (running !== 1'b1) gap = 1;
      starts += int'(cycle_start);
    end
    checks++;
    if (gap || starts != 2) begin
      failures++;
      $display("FAIL blip_gap gap=%0d starts=%0d exp 0 2", gap, starts);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    period_in = W'(10); high_in = W'(3);
    cfg_valid = 1'b1; enable = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (signal_out !== 1'b0 || running !== 1'b0 || active_period !== '0) begin
      failures++;
      $display("FAIL async_rst sig=%b run=%b ap=%0d exp 0 0 0",
               signal_out, running, active_period);
    end
    model_reset();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec() || signal_out !== 1'b0 || running !== 1'b0) begin
        failures++;
        $display("FAIL post_rst got=%h exp=%h", dut_vec(), mdl_vec());
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_random();
    int en_pct;
    do_reset();
    en_pct = 95;
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) en_pct = (en_pct == 95) ? 30 : 95;
      cfg_valid = ($urandom_range(0, 3) == 0);
      period_in = W'($urandom_range(0, 12));
      high_in = W'($urandom_range(0, 12));
      enable = ($urandom_range(0, 99) < en_pct);
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL random c=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
    cfg_valid = 1'b0;
    enable = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_illegal();
    test_midrun_change();
    test_accept_on_wrap();
    test_stop_resume();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/square_wave_gen.md
# square_wave_gen

Programmable square-wave generator that drives a digital output with a configurable period and high time, counted in `clk` cycles. It is the transmit-side counterpart of the period-measuring square-wave frequency detector, and feeds comparator/loopback paths and test fixtures in the 1 kHz–100 kHz band at clocks up to 200 MHz. New settings are accepted through a valid/ready handshake. They take effect only at a period boundary, so the output never produces a runt or glitched pulse.

## Interface
- `COUNTER_WIDTH`, 18: width of the period, high-time and counter paths (200 MHz / 1 kHz = 200 000 < 2^18).
- `MIN_PERIOD`, 2: smallest legal period in cycles.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `period_in` in COUNTER_WIDTH: requested period, in cycles.
- `high_in` in COUNTER_WIDTH: requested high time, in cycles.
- `cfg_valid` in 1: the request on `period_in`/`high_in` is valid.
- `cfg_ready` out 1: the block can accept a request; equals `!pend_valid`.
- `cfg_err` out 1: one-cycle pulse when an accepted request is illegal and discarded.
- `enable` in 1: run request, level-sensitive.
- `signal_out` out 1: registered square-wave output.
- `cycle_start` out 1: registered one-cycle pulse on the first cycle of every period.
- `running` out 1: high while in state RUN.
- `active_period` out COUNTER_WIDTH: period currently in force, for readback.

## Operation
- **Internal state:** active registers `act_period`, `act_high`, `act_ok`; one-deep pending buffer `pend_period`, `pend_high`, `pend_valid`; counter `cnt`; FSM with states IDLE and RUN.
- **Handshake:** a request is accepted when `cfg_valid && cfg_ready`.
- **Legality:** a request is legal iff `period_in >= MIN_PERIOD`, `high_in >= 1` and `high_in < period_in`.
- **Illegal request:** it is still accepted (the handshake completes), then dropped; `cfg_err` pulses. No register changes.
- **Legal request in IDLE:** written straight into the active registers; `act_ok` is set to 1.
- **Legal request in RUN:** written into the pending buffer; `pend_valid` is set to 1.
- **IDLE:**
  - `cnt` = 0, `signal_out` = 0.
  - Moves to RUN when `enable && act_ok`. The evaluation uses the active values as updated by any request accepted in the same cycle.
  - On that transition: `cnt` <= 0, `signal_out` <= 1, `cycle_start` <= 1.
- **RUN:**
  - Wrap condition: `cnt == act_period-1`. On wrap, `cnt` goes to 0; otherwise `cnt` <= `cnt+1`.
  - `signal_out` <= (`cnt_next < act_high`). The output is therefore high for exactly `act_high` cycles of every `act_period`-cycle period.
  - On wrap with `pend_valid`: active <= pending, `pend_valid` <= 0. The new period begins with the new values, starting high.
  - On wrap with `enable` low: go to IDLE, `signal_out` <= 0, `cycle_start` stays 0, and the pending buffer is kept. The current period is always completed.
  - If `enable` deasserts and then reasserts before the wrap, the output continues with no interruption.
- **Simultaneous events:**
  - Accept and wrap in the same cycle, with the pending buffer empty: the request goes to pending and is applied at the following wrap, not the current one.
  - Pending buffer full and wrap in the same cycle: `cfg_ready` is low, so no accept can occur; the transfer pending -> active happens.
- **Pending buffer in IDLE:** a pending request left over from RUN moves to active on the first IDLE cycle.
- **Arithmetic:** all comparisons are unsigned at COUNTER_WIDTH bits. `act_period-1` cannot underflow because `act_period >= MIN_PERIOD`.

## Timing
- **Reset values:**
  - `signal_out`, `cycle_start`, `running`, `cfg_err` = 0.
  - `active_period` = 0, `act_ok` = 0, `pend_valid` = 0.
  - `cfg_ready` = 1, both during and after reset.
- **Reset mid-operation:** the output drops to 0 asynchronously and all configuration is lost.
- **Start latency:** with `enable` sampled high at edge k, `signal_out` rises, `cycle_start` pulses and `running` goes high after edge k.
- **Config-error latency:** `cfg_err` is asserted in the cycle after the accepting edge.
- **Period-change latency:** the change is visible at the first wrap after the request is accepted.
- **Stop latency:** `signal_out` is 0 after the wrap edge that ends the last period; `running` falls on the same edge.
- **Throughput:** one request per period while running; one per cycle while idle.

## Test plan
- **Basic run:** program 10/3, `enable`=1 -> `signal_out` repeats 3 high, 7 low; `cycle_start` every 10 cycles; `active_period` = 10.
- **Illegal requests:** 1/0, 5/5 and 5/0 -> each gives one `cfg_err` pulse, `act_ok` stays 0, and `enable` produces no output.
- **Mid-run change:** running 10/3, request 4/2 at count 5 -> the current period completes as 3/7, then 2 high/2 low; `cfg_ready` is low from the accepting edge until the wrap edge.
- **Accept on wrap:** running 8/4, request 6/1 accepted on the wrap cycle -> one more 8/4 period, then 6/1.
- **Stop and resume:** drop `enable` at count 2 of 10/3 -> the period finishes, then `signal_out` = 0 and `running` = 0. Drop `enable` and raise it again before the wrap -> no gap in the output.
- **Async reset:** assert `rst_n` low mid-high phase -> `signal_out` is 0 immediately. After release, `enable` alone does not start the output (`act_ok` = 0).
